// File: rtl/dev_burst_pkg.sv
// Shared state encoding and transfer-direction constants for the burst sequencer.
package dev_burst_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_STORE = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_LOAD  = ST_LOAD,
        S_ISSUE = ST_ISSUE,
        S_HOLD  = ST_HOLD,
        S_WAIT  = ST_WAIT,
        S_STORE = ST_STORE,
        S_DONE  = ST_DONE
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/xfer_watchdog.sv
// Per-beat timeout counter: counts cycles while run is high, expired flags the
// TIMEOUT_CYCLES-th such cycle. TIMEOUT_CYCLES = 0 disables it.
module xfer_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (TIMEOUT_CYCLES > 0) && run && (r_count == LAST);
    assign expired    = w_at_limit;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && !w_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dev_burst_ctrl.sv
// Burst sequencer: runs cmd_len single-beat transfers on the d1_* master port,
// moving data between the bus and a local single-port synchronous BRAM.
module dev_burst_ctrl
    import dev_burst_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int LEN_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_mode,
    input  logic [ADDR_WIDTH-1:0]     cmd_bus_addr,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_mem_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     d1_addr,
    output logic [DATA_WIDTH-1:0]     d1_wdata,
    output logic                      d1_valid,
    output logic                      d1_mode,
    input  logic                      d1_ready,
    input  logic [DATA_WIDTH-1:0]     d1_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_wen,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_mode;
    logic [ADDR_WIDTH-1:0]     r_bus_addr;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;

    logic w_accept;
    logic w_advance;
    logic w_last;
    logic w_expired;
    logic w_wd_clear;
    logic w_wd_run;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_last     = (r_remaining == LEN_WIDTH'(1));
    assign w_wd_clear = (r_state == S_ISSUE);
    assign w_wd_run   = (r_state == S_WAIT);

    xfer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_wd_clear),
        .run    (w_wd_run),
        .expired(w_expired)
    );

    assign d1_addr   = r_bus_addr;
    assign d1_wdata  = r_wdata;
    assign d1_mode   = r_mode;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_rdata;
    assign err       = done & r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        d1_valid  = 1'b0;
        mem_wen   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_next = S_DONE;
                    end else if (cmd_mode == MODE_WRITE) begin
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_ISSUE;
            S_ISSUE: begin
                d1_valid = 1'b1;
                w_next   = S_HOLD;
            end
            S_HOLD:  w_next = S_WAIT;
            S_WAIT: begin
                // A ready on the expiring cycle still completes the beat.
                if (d1_ready) begin
                    if (r_mode == MODE_READ) begin
                        w_next = S_STORE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = w_last ? S_DONE : S_FETCH;
                    end
                end else if (w_expired) begin
                    w_next = S_DONE;
                end
            end
            S_STORE: begin
                mem_wen   = 1'b1;
                w_advance = 1'b1;
                w_next    = w_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_READ;
            r_bus_addr  <= '0;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode      <= cmd_mode;
                r_bus_addr  <= cmd_bus_addr;
                r_mem_addr  <= cmd_mem_addr;
                r_remaining <= cmd_len;
                r_err       <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_wdata <= mem_rdata;
            end
            if ((r_state == S_WAIT) && d1_ready && (r_mode == MODE_READ)) begin
                r_rdata <= d1_rdata;
            end
            if ((r_state == S_WAIT) && !d1_ready && w_expired) begin
                r_err <= 1'b1;
            end
            // Both address counters wrap naturally at their register width.
            if (w_advance) begin
                r_bus_addr  <= r_bus_addr + ADDR_WIDTH'(1);
                r_mem_addr  <= r_mem_addr + MEM_ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dev_burst_ctrl.sv
// Directed bench for dev_burst_ctrl: a small bus-device and BRAM model around the
// DUT, one task per scenario, hand-computed expectations.
module tb_dev_burst_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MW = 5;
    localparam int LW = 5;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [AW-1:0] cmd_bus_addr;
    logic [MW-1:0] cmd_mem_addr;
    logic [LW-1:0] cmd_len;
    logic          done;
    logic          err;
    logic          busy;
    logic [AW-1:0] d1_addr;
    logic [DW-1:0] d1_wdata;
    logic          d1_valid;
    logic          d1_mode;
    logic          d1_ready;
    logic [DW-1:0] d1_rdata;
    logic [MW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dev_burst_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MEM_ADDR_WIDTH(MW),
        .LEN_WIDTH     (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_bus_addr(cmd_bus_addr),
        .cmd_mem_addr(cmd_mem_addr),
        .cmd_len     (cmd_len),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .d1_addr     (d1_addr),
        .d1_wdata    (d1_wdata),
        .d1_valid    (d1_valid),
        .d1_mode     (d1_mode),
        .d1_ready    (d1_ready),
        .d1_rdata    (d1_rdata),
        .mem_addr    (mem_addr),
        .mem_wen     (mem_wen),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous BRAM with a bench-side preload port.
    logic [DW-1:0] bram [0:31];
    logic          tb_load;
    logic [MW-1:0] tb_load_addr;
    logic [DW-1:0] tb_load_data;

    always @(posedge clk) begin
        if (tb_load) bram[tb_load_addr] <= tb_load_data;
        else if (mem_wen) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    int            cyc;
    int            n_valid;
    int            n_wen;
    int            n_done;
    int            n_acc;
    int            n_stray_err;
    int            n_bad_ready;
    int            done_cyc;
    logic          done_err;
    logic          post_ready;
    logic [AW-1:0] v_addr  [16];
    logic [DW-1:0] v_wdata [16];
    logic          v_mode  [16];
    logic [MW-1:0] w_addr  [16];
    logic [DW-1:0] w_data  [16];
    logic [DW-1:0] rd_data [16];
    int            dev_cnt;
    int            dev_delay;
    int            stall_beat;

    task automatic clear_log();
        cyc = 0; n_valid = 0; n_wen = 0; n_done = 0; n_acc = 0;
        n_stray_err = 0; n_bad_ready = 0; done_cyc = -1; done_err = 1'b0;
        dev_cnt = 0;
    endtask

    // One clock: sample at the falling edge, then update the bus-device model.
    // The device drops ready on a request and raises it so that WAIT lasts dev_delay cycles.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dev_cnt > 0) begin
            dev_cnt--;
            if (dev_cnt == 0) d1_ready = 1'b1;
        end
        if (d1_valid) begin
            if (n_valid < 16) begin
                v_addr[n_valid]  = d1_addr;
                v_wdata[n_valid] = d1_wdata;
                v_mode[n_valid]  = d1_mode;
                d1_rdata         = rd_data[n_valid];
            end
            d1_ready = 1'b0;
            dev_cnt  = (n_valid == stall_beat) ? 0 : dev_delay + 1;
            n_valid++;
        end
        if (mem_wen) begin
            if (n_wen < 16) begin
                w_addr[n_wen] = mem_addr;
                w_data[n_wen] = mem_wdata;
            end
            n_wen++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_err = err;
        end
        if (err && !done) n_stray_err++;
        if (busy && cmd_ready) n_bad_ready++;
        if (cmd_valid && cmd_ready) n_acc++;
    endtask

    task automatic load(input logic [MW-1:0] a, input logic [DW-1:0] d);
        tb_load = 1'b1; tb_load_addr = a; tb_load_data = d;
        step();
        tb_load = 1'b0;
    endtask

    // Issue one command (accepted at the next rising edge) and follow it to done,
    // a cycle budget, or the abort cycle; cmd_* are scrambled right after acceptance.
    task automatic run_cmd(input logic mode, input logic [AW-1:0] bus, input logic [MW-1:0] mem,
                           input logic [LW-1:0] len, input int delay, input int stall,
                           input int abort_at);
        clear_log();
        dev_delay = delay; stall_beat = stall; d1_ready = 1'b1;
        cmd_mode = mode; cmd_bus_addr = bus; cmd_mem_addr = mem; cmd_len = len;
        cmd_valid = 1'b1;
        while (n_done == 0 && cyc < 200 && cyc != abort_at) begin
            step();
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                cmd_mode = ~mode; cmd_bus_addr = ~bus; cmd_mem_addr = ~mem; cmd_len = ~len;
            end
        end
        post_ready = 1'b0;
        if (n_done != 0) begin
            step();
            post_ready = cmd_ready && !busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_bus_addr = '0; cmd_mem_addr = '0;
        cmd_len = '0; d1_ready = 1'b1; d1_rdata = '0; tb_load = 1'b0; tb_load_addr = '0;
        tb_load_data = '0; stall_beat = -1; dev_delay = 1;
        for (int i = 0; i < 16; i++) rd_data[i] = '0;
        clear_log();
        step();
        step();
        checks++;
        if ({cmd_ready, busy, done, err, d1_valid, d1_mode, mem_wen} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected %b",
                     {cmd_ready, busy, done, err, d1_valid, d1_mode, mem_wen}, 7'b1000000);
        end
        checks++;
        if ({d1_addr, d1_wdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", {d1_addr, d1_wdata, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 100", {cmd_ready, busy, done});
        end
    endtask

    task automatic test_write_burst();
        logic [AW-1:0] ea [3];
        logic [DW-1:0] ed [3];
        ea = '{16'h8001, 16'h8002, 16'h8003};
        ed = '{8'hA1, 8'hB2, 8'hC3};
        load(5'h1E, 8'hA1);
        load(5'h1F, 8'hB2);
        load(5'h00, 8'hC3);
        run_cmd(1'b1, 16'h8001, 5'h1E, 5'd3, 2, -1, -1);
        checks++;
        if (done_cyc !== 19) begin
            errors++; $display("FAIL wr_done_cycle: got %0d, expected 19", done_cyc);
        end
        checks++;
        if (done_err !== 1'b0) begin
            errors++; $display("FAIL wr_err: got %b, expected 0", done_err);
        end
        checks++;
        if (n_valid !== 3) begin
            errors++; $display("FAIL wr_valid_count: got %0d, expected 3", n_valid);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({v_addr[i], v_wdata[i], v_mode[i]} !== {ea[i], ed[i], 1'b1}) begin
                errors++;
                $display("FAIL wr_beat%0d: got addr %h data %h mode %b, expected addr %h data %h mode 1",
                         i, v_addr[i], v_wdata[i], v_mode[i], ea[i], ed[i]);
            end
        end
        checks++;
        if ({n_wen, n_stray_err, n_bad_ready} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL wr_side_effects: got wen %0d stray_err %0d bad_ready %0d, expected 0 0 0",
                     n_wen, n_stray_err, n_bad_ready);
        end
        checks++;
        if (post_ready !== 1'b1) begin
            errors++; $display("FAIL wr_ready_after_done: got %b, expected 1", post_ready);
        end
    endtask

    task automatic test_read_burst();
        rd_data[0] = 8'h5A;
        rd_data[1] = 8'h6B;
        run_cmd(1'b0, 16'hFFFF, 5'h10, 5'd2, 1, -1, -1);
        checks++;
        if ({done_cyc, done_err} !== {32'd9, 1'b0}) begin
            errors++; $display("FAIL rd_done: got cycle %0d err %b, expected 9 0", done_cyc, done_err);
        end
        checks++;
        if (n_valid !== 2 || v_addr[0] !== 16'hFFFF || v_addr[1] !== 16'h0000) begin
            errors++;
            $display("FAIL rd_bus_addr: got %0d pulses %h %h, expected 2 pulses ffff 0000",
                     n_valid, v_addr[0], v_addr[1]);
        end
        checks++;
        if ({v_mode[0], v_mode[1]} !== 2'b00) begin
            errors++; $display("FAIL rd_mode: got %b, expected 00", {v_mode[0], v_mode[1]});
        end
        checks++;
        if (n_wen !== 2 || {w_addr[0], w_data[0], w_addr[1], w_data[1]} !== {5'h10, 8'h5A, 5'h11, 8'h6B}) begin
            errors++;
            $display("FAIL rd_mem_writes: got %0d writes %h@%h %h@%h, expected 2 writes 5a@10 6b@11",
                     n_wen, w_data[0], w_addr[0], w_data[1], w_addr[1]);
        end
        checks++;
        if ({bram[16], bram[17]} !== {8'h5A, 8'h6B}) begin
            errors++; $display("FAIL rd_bram: got %h %h, expected 5a 6b", bram[16], bram[17]);
        end
        checks++;
        if ({post_ready, n_stray_err == 0} !== 2'b11) begin
            errors++;
            $display("FAIL rd_finish: got ready %b stray_err %0d, expected 1 0", post_ready, n_stray_err);
        end
    endtask

    task automatic test_zero_len();
        run_cmd(1'b1, 16'h5555, 5'h0A, 5'd0, 1, -1, -1);
        checks++;
        if ({done_cyc, done_err} !== {32'd1, 1'b0}) begin
            errors++; $display("FAIL len0_done: got cycle %0d err %b, expected 1 0", done_cyc, done_err);
        end
        checks++;
        if ({n_valid, n_wen} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL len0_activity: got valid %0d wen %0d, expected 0 0", n_valid, n_wen);
        end
        checks++;
        if (post_ready !== 1'b1) begin
            errors++; $display("FAIL len0_ready: got %b, expected 1", post_ready);
        end
    endtask

    task automatic test_timeout();
        run_cmd(1'b0, 16'h1234, 5'h00, 5'd4, 1, 0, -1);
        checks++;
        if ({done_cyc, done_err} !== {32'd11, 1'b1}) begin
            errors++; $display("FAIL to_done: got cycle %0d err %b, expected 11 1", done_cyc, done_err);
        end
        checks++;
        if ({n_valid, n_wen, n_stray_err} !== {32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL to_activity: got valid %0d wen %0d stray_err %0d, expected 1 0 0",
                     n_valid, n_wen, n_stray_err);
        end
        clear_log();
        d1_ready = 1'b1;
        repeat (4) step();
        checks++;
        if ({n_valid, n_wen, n_done} !== {32'd0, 32'd0, 32'd0} || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_late_ready: got valid %0d wen %0d done %0d ready %b busy %b, expected 0 0 0 1 0",
                     n_valid, n_wen, n_done, cmd_ready, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        rd_data[0] = 8'h77;
        run_cmd(1'b0, 16'h4000, 5'h05, 5'd3, 1, 1, 8);
        checks++;
        if ({busy, d1_addr, mem_addr, mem_wdata} !== {1'b1, 16'h4001, 5'h06, 8'h77}) begin
            errors++;
            $display("FAIL rst_pre: got busy %b addr %h mem %h wdata %h, expected 1 4001 06 77",
                     busy, d1_addr, mem_addr, mem_wdata);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy, done, err, d1_valid, d1_mode, mem_wen} !== 7'b1000000) begin
            errors++;
            $display("FAIL rst_async_ctrl: got %b, expected %b",
                     {cmd_ready, busy, done, err, d1_valid, d1_mode, mem_wen}, 7'b1000000);
        end
        checks++;
        if ({d1_addr, d1_wdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_async_data: got %h, expected 0", {d1_addr, d1_wdata, mem_addr, mem_wdata});
        end
        step();
        step();
        rst = 1'b0;
        clear_log();
        d1_ready = 1'b1;
        repeat (4) step();
        checks++;
        if ({n_done, n_valid, n_wen} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_no_done: got done %0d valid %0d wen %0d, expected 0 0 0", n_done, n_valid, n_wen);
        end
        load(5'h03, 8'h3C);
        load(5'h04, 8'h4D);
        run_cmd(1'b1, 16'h0100, 5'h03, 5'd2, 1, -1, -1);
        checks++;
        if ({done_cyc, done_err, post_ready} !== {32'd11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_new_done: got cycle %0d err %b ready %b, expected 11 0 1",
                     done_cyc, done_err, post_ready);
        end
        checks++;
        if (n_valid !== 2 || {v_addr[0], v_wdata[0], v_addr[1], v_wdata[1]} !== {16'h0100, 8'h3C, 16'h0101, 8'h4D}) begin
            errors++;
            $display("FAIL rst_new_beats: got %0d pulses %h:%h %h:%h, expected 2 pulses 0100:3c 0101:4d",
                     n_valid, v_addr[0], v_wdata[0], v_addr[1], v_wdata[1]);
        end
    endtask

    task automatic test_back_to_back();
        load(5'h09, 8'h99);
        clear_log();
        dev_delay = 1; stall_beat = -1; d1_ready = 1'b1;
        rd_data[0] = 8'hE5;
        cmd_mode = 1'b0; cmd_bus_addr = 16'h2000; cmd_mem_addr = 5'h08; cmd_len = 5'd1;
        cmd_valid = 1'b1;
        while (n_done < 2 && cyc < 60) begin
            step();
            if (cyc == 1) begin
                cmd_mode = 1'b1; cmd_bus_addr = 16'h3000; cmd_mem_addr = 5'h09; cmd_len = 5'd1;
            end
            if (cyc == 7) cmd_valid = 1'b0;
        end
        step();
        checks++;
        if ({n_acc, n_bad_ready, n_done} !== {32'd1, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL b2b_accepts: got accepts %0d ready_while_busy %0d dones %0d, expected 1 0 2",
                     n_acc, n_bad_ready, n_done);
        end
        checks++;
        if (done_cyc !== 12) begin
            errors++; $display("FAIL b2b_second_done: got %0d, expected 12", done_cyc);
        end
        checks++;
        if (n_valid !== 2 || {v_addr[0], v_mode[0], v_addr[1], v_mode[1], v_wdata[1]} !==
                             {16'h2000, 1'b0, 16'h3000, 1'b1, 8'h99}) begin
            errors++;
            $display("FAIL b2b_beats: got %0d pulses %h/%b %h/%b/%h, expected 2 pulses 2000/0 3000/1/99",
                     n_valid, v_addr[0], v_mode[0], v_addr[1], v_mode[1], v_wdata[1]);
        end
        checks++;
        if (n_wen !== 1 || {w_addr[0], w_data[0]} !== {5'h08, 8'hE5}) begin
            errors++;
            $display("FAIL b2b_mem_write: got %0d writes %h@%h, expected 1 write e5@08", n_wen, w_data[0], w_addr[0]);
        end
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL b2b_idle: got ready %b busy %b, expected 1 0", cmd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_zero_len();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dev_burst_ctrl.md
# dev_burst_ctrl

Burst sequencer for the bus master device port (d1_*). It accepts one command: a direction, a bus start address, a local memory start address and a length. It then runs that many single-beat transfers back to back on the master port, moving data between the bus and a local single-port synchronous BRAM. It replaces hand-sequenced single transfers in demo and test tops, and reports completion or timeout per command.

## Interface
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, data width
- MEM_ADDR_WIDTH, 5, local BRAM address width
- LEN_WIDTH, 5, burst length field width
- TIMEOUT_CYCLES, 1024, maximum wait for d1_ready per beat; 0 disables the watchdog

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only. A command is accepted when cmd_valid && cmd_ready.
- cmd_mode  in  1  0 = bus read to memory, 1 = memory to bus write.
- cmd_bus_addr  in  ADDR_WIDTH  first bus address.
- cmd_mem_addr  in  MEM_ADDR_WIDTH  first BRAM address.
- cmd_len  in  LEN_WIDTH  number of beats; 0 is legal.
- done  out  1  one-cycle pulse at the end of a command.
- err  out  1  valid with done; 1 = the burst ended by timeout.
- busy  out  1  high whenever not IDLE.
- d1_addr  out  ADDR_WIDTH  bus address.
- d1_wdata  out  DATA_WIDTH  write data.
- d1_valid  out  1  request pulse.
- d1_mode  out  1  transfer direction.
- d1_ready  in  1  bus master device idle.
- d1_rdata  in  DATA_WIDTH  read data.
- mem_addr  out  MEM_ADDR_WIDTH  BRAM address.
- mem_wen  out  1  BRAM write enable.
- mem_wdata  out  DATA_WIDTH  BRAM write data.
- mem_rdata  in  DATA_WIDTH  BRAM q; one-cycle read latency.

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, HOLD, WAIT, STORE, DONE.
- Acceptance latches mode, bus address, memory address and length into registers; later changes on cmd_* have no effect.
  - len=0 goes straight to DONE: no d1_valid, no mem_wen, err=0.
  - Otherwise mode=1 goes to FETCH and mode=0 goes to ISSUE.
- FETCH: mem_addr is the memory address register. The BRAM samples it at the end of the cycle.
- LOAD: the wdata register takes mem_rdata.
- ISSUE: d1_valid=1 for exactly this cycle. d1_addr, d1_mode and d1_wdata are registers held stable from ISSUE through the end of WAIT.
- HOLD: one guard cycle; d1_ready is ignored.
- WAIT: stay until d1_ready=1.
  - Mode 0 exit: capture d1_rdata and go to STORE.
  - Mode 1 exit: go to the next-beat decision.
- STORE (mode 0 only): mem_wen=1 and mem_wdata = captured data for this single cycle. Then the next-beat decision.
- Next-beat decision:
  - Bus address +1, wrapping modulo 2^ADDR_WIDTH.
  - Memory address +1, wrapping modulo 2^MEM_ADDR_WIDTH.
  - Remaining count −1.
  - Remaining = 0 goes to DONE; otherwise FETCH (mode 1) or ISSUE (mode 0).
- Watchdog: counts cycles in WAIT and clears on entry to ISSUE. Reaching TIMEOUT_CYCLES goes to DONE with err=1 and abandons the remaining beats. A late d1_ready is then ignored.
- DONE: done=1 for one cycle, then IDLE.

## Timing
- Reset values: cmd_ready=1 (state IDLE). done, err, busy, d1_valid, d1_mode, mem_wen = 0. d1_addr, d1_wdata, mem_addr, mem_wdata = 0.
- Reset asserted mid-burst forces IDLE and drops d1_valid and mem_wen asynchronously. There is no done pulse and no partial-burst completion.
- Cycles per beat, with W = cycles in WAIT (≥1):
  - Mode 1: 4+W (FETCH, LOAD, ISSUE, HOLD, WAIT).
  - Mode 0: 3+W (ISSUE, HOLD, WAIT, STORE).
- Command latency: the accept edge is followed by the beat cycles and then one DONE cycle. cmd_ready rises the cycle after done.
- err is meaningful only while done=1; otherwise 0.
- cmd_valid is never accepted outside IDLE, including in DONE.

## Structure
- Shared package dev_burst_pkg holds:
  - the state encoding localparams (3-bit);
  - the MODE_READ=0 / MODE_WRITE=1 constants.
- One sub-module, xfer_watchdog, holds the timeout counter. Its ports are clk, rst, clear, run and expired; counter width is $clog2(TIMEOUT_CYCLES+1).
- Everything else stays in one FSM plus datapath registers.

## Test plan
- Mode 1 write, len=3, mem_addr=0x1E, bus 0x8001. BRAM[0x1E,0x1F,0x00] = A1, B2, C3; d1_ready returns 2 cycles after HOLD.
  - Three d1_valid pulses at 0x8001..0x8003 with wdata A1, B2, C3; the memory address wraps 0x1F→0x00.
  - done=1 and err=0 at cycle 3·(4+2)+1 after accept.
- Mode 0 read, len=2, bus 0xFFFF, mem 0x10; the bus returns 5A, 6B.
  - d1_addr is 0xFFFF then 0x0000.
  - mem_wen pulses write 5A@0x10 and 6B@0x11.
- len=0: done pulses the cycle after accept, err=0; d1_valid and mem_wen never assert.
- TIMEOUT_CYCLES=8, d1_ready held low after beat 1 of len=4.
  - done with err=1 after 8 WAIT cycles; only one d1_valid pulse is issued.
  - A later d1_ready is ignored and cmd_ready=1.
- rst asserted during the WAIT of beat 2:
  - outputs go immediately to their reset values and there is no done;
  - a new command after release runs correctly from its own addresses.
- cmd_valid held high throughout: exactly one acceptance per IDLE visit, and inputs changed mid-burst do not alter the addresses in use.
